// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph constants, BCD-to-segment decode and converter FSM states
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_e;

  // Segments are active low; non-decimal nibbles render as blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-add-3 binary to BCD converter with load/ready handshake
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  clk_50mHz,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  load,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic                  commit
);

  localparam int          BCD_W = 4 * DIGITS;
  localparam int          CNT_W = $clog2(BIN_W);
  localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [31:0]        bin_ext;

  assign bin_ext = 32'(bin);

  always_ff @(posedge clk_50mHz) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          sr_d    = bin;
          bcd_d   = '0;
          cnt_d   = CNT_W'(BIN_W - 1);
          ovf_d   = (bin_ext >= LIMIT);
          state_d = CONV;
        end
      end
      CONV: begin
        // Carry out of the top nibble is dropped; ovf already flags that case.
        bcd_d = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1]};
        sr_d  = {sr_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign commit = (state_q == COMMIT);
  assign bcd    = bcd_q;
  assign ovf    = ovf_q;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment decimal display driver
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int BIN_W         = 8,
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV_W = 18,
  parameter int BLANK_LZ      = 1
) (
  input  logic               clk_50mHz,
  input  logic               rst_n,
  input  logic [BIN_W-1:0]   bin,
  input  logic               load,
  output logic               ready,
  output logic               overflow,
  output logic [6:0]         a_to_g,
  output logic [DIGITS-1:0]  an
);

  localparam int                BCD_W  = 4 * DIGITS;
  localparam int                DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] AN_RST = ~(DIGITS'(1));

  logic [BCD_W-1:0]          bcd;
  logic                      ovf_cand;
  logic                      commit;

  logic [BCD_W-1:0]          disp_q, disp_d;
  logic                      ovf_q, ovf_d;
  logic [REFRESH_DIV_W-1:0]  presc_q, presc_d;
  logic [DIG_W-1:0]          dig_q, dig_d;
  logic [DIGITS-1:0]         an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic [3:0]                nib;
  logic [DIG_W-1:0]          msd;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk_50mHz (clk_50mHz),
    .rst_n     (rst_n),
    .bin       (bin),
    .load      (load),
    .ready     (ready),
    .bcd       (bcd),
    .ovf       (ovf_cand),
    .commit    (commit)
  );

  always_ff @(posedge clk_50mHz) begin
    if (!rst_n) begin
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      presc_q <= '0;
      dig_q   <= '0;
      an_q    <= AN_RST;
      seg_q   <= SEG_0;
    end else begin
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      presc_q <= presc_d;
      dig_q   <= dig_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    dig_d   = dig_q;
    if (&presc_q) dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + 1'b1;

    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (commit) begin
      disp_d = bcd;
      ovf_d  = ovf_cand;
    end

    nib  = 4'd0;
    an_d = '1;
    msd  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'd0) msd = DIG_W'(i);
      if (dig_q == DIG_W'(i)) begin
        nib     = disp_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end

    // msd is 0 for an all-zero value, so digit 0 can never satisfy dig_q > msd.
    if (ovf_q)                              seg_d = SEG_DASH;
    else if (BLANK_LZ != 0 && dig_q > msd)  seg_d = SEG_BLANK;
    else                                    seg_d = bcd_to_seg(nib);
  end

  assign overflow = ovf_q;
  assign an       = an_q;
  assign a_to_g   = seg_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - self-checking bench for seg7_scan_ctrl across four configurations
module tb_seg7_scan_ctrl;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100, GB = 7'b1111111, GD = 7'b1111110;

  typedef struct {
    int                sel;
    int unsigned       val;
    logic              ovf;
    logic [3:0][6:0]   g;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  load;
  logic [7:0]  bin_a, bin_c, bin_e;
  logic [15:0] bin_b;
  logic [3:0]  ready, ovf;
  logic [6:0]  seg_a, seg_b, seg_c, seg_e;
  logic [3:0]  an_a, an_b, an_c;
  logic [2:0]  an_e;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [6:0] glyph_tbl [10];
  vec_t vecs [12];

  seg7_scan_ctrl #(.BIN_W(8), .DIGITS(4), .REFRESH_DIV_W(2), .BLANK_LZ(1)) u_a (
    .clk_50mHz(clk), .rst_n(rst_n), .bin(bin_a), .load(load[0]), .ready(ready[0]),
    .overflow(ovf[0]), .a_to_g(seg_a), .an(an_a));
  seg7_scan_ctrl #(.BIN_W(16), .DIGITS(4), .REFRESH_DIV_W(2), .BLANK_LZ(1)) u_b (
    .clk_50mHz(clk), .rst_n(rst_n), .bin(bin_b), .load(load[1]), .ready(ready[1]),
    .overflow(ovf[1]), .a_to_g(seg_b), .an(an_b));
  seg7_scan_ctrl #(.BIN_W(8), .DIGITS(4), .REFRESH_DIV_W(2), .BLANK_LZ(0)) u_c (
    .clk_50mHz(clk), .rst_n(rst_n), .bin(bin_c), .load(load[2]), .ready(ready[2]),
    .overflow(ovf[2]), .a_to_g(seg_c), .an(an_c));
  seg7_scan_ctrl #(.BIN_W(8), .DIGITS(3), .REFRESH_DIV_W(1), .BLANK_LZ(1)) u_e (
    .clk_50mHz(clk), .rst_n(rst_n), .bin(bin_e), .load(load[3]), .ready(ready[3]),
    .overflow(ovf[3]), .a_to_g(seg_e), .an(an_e));

  // Clock edges since reset release; the scan position follows from this alone.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int bw(input int sel);
    return (sel == 1) ? 16 : 8;
  endfunction
  function automatic int nd(input int sel);
    return (sel == 3) ? 3 : 4;
  endfunction
  function automatic int rw(input int sel);
    return (sel == 3) ? 1 : 2;
  endfunction
  function automatic int lz(input int sel);
    return (sel == 2) ? 0 : 1;
  endfunction
  function automatic int unsigned pow10(input int n);
    int unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] get_seg(input int sel);
    case (sel)
      0:       return seg_a;
      1:       return seg_b;
      2:       return seg_c;
      default: return seg_e;
    endcase
  endfunction
  function automatic logic [3:0] get_an(input int sel);
    case (sel)
      0:       return an_a;
      1:       return an_b;
      2:       return an_c;
      default: return {1'b1, an_e};
    endcase
  endfunction

  function automatic int ref_idx(input int sel);
    if (cyc == 0) return 0;
    return ((cyc - 1) >> rw(sel)) % nd(sel);
  endfunction

  function automatic logic [6:0] ref_glyph(input int sel, input int unsigned v, input int idx);
    int msd = 0;
    int unsigned d;
    if (v >= pow10(nd(sel))) return GD;
    for (int i = 0; i < nd(sel); i++)
      if ((v / pow10(i)) % 10 != 0) msd = i;
    if (lz(sel) == 1 && idx > msd) return GB;
    d = (v / pow10(idx)) % 10;
    return glyph_tbl[d];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_bin(input int sel, input int unsigned v);
    case (sel)
      0:       bin_a = v[7:0];
      1:       bin_b = v[15:0];
      2:       bin_c = v[7:0];
      default: bin_e = v[7:0];
    endcase
  endtask

  task automatic do_load(input int sel, input int unsigned v);
    int n = 0;
    @(negedge clk);
    check("ready before load", 32'(ready[sel]), 32'd1);
    set_bin(sel, v);
    load[sel] = 1'b1;
    @(negedge clk);
    load[sel] = 1'b0;
    set_bin(sel, $urandom);
    while (!ready[sel] && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("busy cycles", n, bw(sel) + 1);
  endtask

  task automatic check_scan(input int sel, input int unsigned v, input int ncyc);
    int idx;
    logic [3:0] an_exp;
    repeat (ncyc) begin
      @(negedge clk);
      idx    = ref_idx(sel);
      an_exp = 4'hF & ~(4'd1 << idx);
      check($sformatf("scan an dut%0d v=%0d", sel, v), get_an(sel), an_exp);
      check($sformatf("scan seg dut%0d v=%0d d%0d", sel, v, idx), get_seg(sel),
            ref_glyph(sel, v, idx));
    end
    check($sformatf("overflow dut%0d v=%0d", sel, v), 32'(ovf[sel]),
          32'(v >= pow10(nd(sel))));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int sel;
    int unsigned v;
    int idx;
    logic [3:0] an_exp;

    glyph_tbl = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9};
    vecs[0]  = '{sel: 0, val: 255,   ovf: 1'b0, g: {GB, G2, G5, G5}};
    vecs[1]  = '{sel: 1, val: 12345, ovf: 1'b1, g: {GD, GD, GD, GD}};
    vecs[2]  = '{sel: 1, val: 9999,  ovf: 1'b0, g: {G9, G9, G9, G9}};
    vecs[3]  = '{sel: 0, val: 0,     ovf: 1'b0, g: {GB, GB, GB, G0}};
    vecs[4]  = '{sel: 2, val: 7,     ovf: 1'b0, g: {G0, G0, G0, G7}};
    vecs[5]  = '{sel: 3, val: 100,   ovf: 1'b0, g: {GB, G1, G0, G0}};
    vecs[6]  = '{sel: 1, val: 10000, ovf: 1'b1, g: {GD, GD, GD, GD}};
    vecs[7]  = '{sel: 0, val: 100,   ovf: 1'b0, g: {GB, G1, G0, G0}};
    vecs[8]  = '{sel: 3, val: 5,     ovf: 1'b0, g: {GB, GB, GB, G5}};
    vecs[9]  = '{sel: 2, val: 0,     ovf: 1'b0, g: {G0, G0, G0, G0}};
    vecs[10] = '{sel: 1, val: 65535, ovf: 1'b1, g: {GD, GD, GD, GD}};
    vecs[11] = '{sel: 3, val: 255,   ovf: 1'b0, g: {GB, G2, G5, G5}};

    rst_n = 1'b0;
    load  = '0;
    bin_a = '0; bin_b = '0; bin_c = '0; bin_e = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", 32'(ready), 32'hF);
    check("reset overflow", 32'(ovf), 32'h0);
    check("reset an a", 32'(an_a), 32'b1110);
    check("reset seg a", 32'(seg_a), 32'(G0));
    check("reset an e", 32'(an_e), 32'b110);
    check("reset seg e", 32'(seg_e), 32'(G0));
    rst_n = 1'b1;
    check_scan(0, 0, 8);

    foreach (vecs[k]) begin
      do_load(vecs[k].sel, vecs[k].val);
      repeat (nd(vecs[k].sel) * (1 << rw(vecs[k].sel)) + 2) begin
        @(negedge clk);
        idx    = ref_idx(vecs[k].sel);
        an_exp = 4'hF & ~(4'd1 << idx);
        check($sformatf("vec%0d an", k), get_an(vecs[k].sel), an_exp);
        check($sformatf("vec%0d seg d%0d", k, idx), get_seg(vecs[k].sel), vecs[k].g[idx]);
      end
      check($sformatf("vec%0d overflow", k), 32'(ovf[vecs[k].sel]), 32'(vecs[k].ovf));
    end

    // A low pulse on rst_n that misses every rising edge must not reset anything.
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check_scan(1, 65535, 8);
    check_scan(2, 0, 8);

    // Load during conversion is dropped, not queued.
    @(negedge clk);
    bin_a   = 8'd42;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    bin_a   = 8'd100;
    n = 0;
    while (!ready[0] && n < 200) begin
      n++;
      load[0] = (n == 3);
      @(negedge clk);
    end
    load[0] = 1'b0;
    check("busy with ignored load", n, 9);
    repeat (4) begin
      @(negedge clk);
      check("ready stays high", 32'(ready[0]), 32'd1);
    end
    check_scan(0, 42, 16);

    // Reset in the middle of a conversion abandons it.
    @(negedge clk);
    bin_a   = 8'd200;
    load[0] = 1'b1;
    @(negedge clk);
    load[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("ready after mid-conv reset", 32'(ready[0]), 32'd1);
    repeat (12) @(negedge clk);
    check_scan(0, 0, 16);
    check_scan(1, 0, 8);

    check_scan(3, 0, 12);

    for (int it = 0; it < 30; it++) begin
      sel = $urandom_range(0, 3);
      v   = $urandom % (32'd1 << bw(sel));
      if (sel == 1 && $urandom_range(0, 1) == 1) v = $urandom_range(0, 10050);
      do_load(sel, v);
      check_scan(sel, v, nd(sel) * (1 << rw(sel)) * 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
